aes_spi_frontend: RTL
=====================

// Module: aes_spi_frontend
// PURPOSE
//  SPI slave between the Pi and the AES core. Shifts in dir, key and message, drives the core's
//  ce (load) and captures translated on done. Shifts the result back to the Pi in the next frame.
//  Serial pins are oversampled and synchronised in the clk domain; no logic is clocked by sck.
// PARAMETERS
//  K            128  key length (128/192/256); must match the core's K
//  SYNC_STAGES  2    flop stages on sck, sdi and load before use (>=2)
// PORTS
//  clk         in   1      system clock
//  reset       in   1      asynchronous, active-low reset
//  sck         in   1      SPI clock from the Pi; period >= 8 clk cycles
//  sdi         in   1      SPI data in, MSB first, sampled on sck rising edge
//  load        in   1      frame enable from the Pi; high for the whole frame
//  sdo         out  1      SPI data out, MSB first, changes after sck falling edge
//  ready       out  1      result captured, available to Pi
//  frame_err   out  1      last frame had wrong bit count (AES_SPI_FRAMECHK_EN only, else 0)
//  ce          out  1      to core: high = load/hold, falling edge starts the operation
//  dir         out  1      to core: 0 encrypt, 1 decrypt
//  key         out  K      to core
//  message     out  128    to core
//  done        in   1      from core: result valid (level)
//  translated  in   128    from core
// BEHAVIOUR
//  Reset values: sdo=0, ready=0, frame_err=0, ce=1, dir=0, key=0, message=0, result reg=0, state IDLE.
//  Frame: FRAME_LEN = 1+K+128 bits, order dir, key[K-1:0], message[127:0], all MSB first.
//  Edge detect on synchronised sck (prev/cur flops); latency from pin edge to action =
//  SYNC_STAGES+1 clk cycles.
//  FSM:
//   IDLE  : ce=1. load rise -> SHIFT; clear bitcnt, ready=0, frame_err=0; preload out shreg with result.
//   SHIFT : ce=1. sck rise: in shreg <= {in shreg, sdi}; bitcnt++ saturating at FRAME_LEN.
//           sck fall: out shreg <<= 1; sdo = out shreg MSB; zeros after 128 bits.
//           load fall -> RUN, with dir/key/message loaded from in shreg in that cycle.
//   RUN   : ce=0 (core runs). done high -> capture translated into result, ready=1 -> DONE.
//   DONE  : ce=0, ready held high. load rise -> SHIFT (new frame, result shifts out).
//  Boundaries:
//   - load rise in RUN (core not finished): abort. ce=1 at once (core resets); result unchanged;
//     ready=0; -> SHIFT.
//   - sck edges while load low are ignored; sdi is ignored outside SHIFT.
//   - More than FRAME_LEN bits: extra bits shift through; the last FRAME_LEN bits win.
//   - done high in the cycle ce falls: ignored; capture needs done seen in RUN only.
//   - reset mid-operation: immediate return to reset values; core sees ce=1 and stops.
// CONFIGURATION
//  `AES_SPI_FRAMECHK_EN defined: at load fall, if bitcnt != FRAME_LEN -> ERROR state.
//   ERROR: ce=1 (core held), frame_err=1, key/message/dir not updated. Leave via load rise -> SHIFT.
//  Undefined: no length check, frame_err tied 0. Every load fall -> RUN with in shreg contents.
// STRUCTURE
//  Package aes_pkg: typedef enum logic [2:0] {IDLE,SHIFT,RUN,DONE,ERROR} spi_state_t;
//   function frame_len(K); localparams for K=128/192/256.
//  Sub-module: spi_sync_edge (SYNC_STAGES synchroniser + rise/fall pulse), one instance each
//   for sck and load; sdi uses the synchroniser only.
//  Top holds the FSM, bitcnt ($clog2(FRAME_LEN+1) bits), in/out shift registers and result reg.
// TESTING (core model or real aes core, sck = clk/10)
//  1 Encrypt FIPS-197: dir=0, key 000102..0f, msg 00112233..ff -> ce falls at load fall;
//    ready=1 after done; next frame shifts out 69c4e0d86a7b0430d8cdb78070b4c55a.
//  2 Decrypt: dir=1, same key, msg 69c4e0d8..c55a -> result 00112233445566778899aabbccddeeff.
//  3 Abort: load rises 3 sck periods into RUN -> ce=1 within SYNC_STAGES+2 clk; ready stays 0;
//    result reg keeps the previous value.
//  4 Short frame (FRAME_LEN-1 bits) with FRAMECHK on -> frame_err=1, ce stays 1, key unchanged;
//    with it off -> RUN entered.
//  5 Reset asserted in SHIFT and again in RUN -> all outputs at reset values the same cycle;
//    the next clean frame works.
//  6 K=256 build: 385-bit frame decrypts the FIPS-197 AES-256 vector correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and frame-length helpers for the AES SPI front end.
package aes_pkg;

   typedef enum logic [2:0] {IDLE, SHIFT, RUN, DONE, ERROR} spi_state_t;

   // One direction bit, the key, then the 128-bit message.
   function automatic int frame_len(input int k);
      return 1 + k + 128;
   endfunction

   localparam int FRAME_LEN_128 = 1 + 128 + 128;
   localparam int FRAME_LEN_192 = 1 + 192 + 128;
   localparam int FRAME_LEN_256 = 1 + 256 + 128;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall pulses
// taken from the synchronised level against its previous value.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/aes_spi_frontend.sv
// SPI slave feeding dir/key/message to the AES core and returning its result.
// Optional frame-length check enabled by defining AES_SPI_FRAMECHK_EN.
module aes_spi_frontend
   import aes_pkg::*;
#(
   parameter int K           = 128,
   parameter int SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           sck,
   input  logic           sdi,
   input  logic           load,
   output logic           sdo,
   output logic           ready,
   output logic           frame_err,
   output logic           ce,
   output logic           dir,
   output logic [K-1:0]   key,
   output logic [127:0]   message,
   input  logic           done,
   input  logic [127:0]   translated
);

   localparam int FRAME_LEN = frame_len(K);
   localparam int CNT_W     = $clog2(FRAME_LEN + 1);

   logic sck_s, sck_rise, sck_fall;
   logic load_s, load_rise, load_fall;
   logic [SYNC_STAGES-1:0] sdi_sync_q;
   logic sdi_s;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
      .clk(clk), .rst_n(reset), .d_i(sck),
      .level_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
      .clk(clk), .rst_n(reset), .d_i(load),
      .level_o(load_s), .rise_o(load_rise), .fall_o(load_fall)
   );

   // sdi goes through the same depth as sck so data lines up with the sampled edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sdi_sync_q <= '0;
      else        sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
   end
   assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

   spi_state_t           state_q, state_d;
   logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
   logic [FRAME_LEN-1:0] in_sr_q, in_sr_d;
   logic [127:0]         out_sr_q, out_sr_d;
   logic [127:0]         result_q, result_d;
   logic                 ready_q, ready_d;
   logic                 frame_err_q, frame_err_d;
   logic                 dir_q, dir_d;
   logic [K-1:0]         key_q, key_d;
   logic [127:0]         msg_q, msg_d;
   logic                 start;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         bitcnt_q    <= '0;
         in_sr_q     <= '0;
         out_sr_q    <= '0;
         result_q    <= '0;
         ready_q     <= 1'b0;
         frame_err_q <= 1'b0;
         dir_q       <= 1'b0;
         key_q       <= '0;
         msg_q       <= '0;
      end else begin
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         in_sr_q     <= in_sr_d;
         out_sr_q    <= out_sr_d;
         result_q    <= result_d;
         ready_q     <= ready_d;
         frame_err_q <= frame_err_d;
         dir_q       <= dir_d;
         key_q       <= key_d;
         msg_q       <= msg_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bitcnt_d    = bitcnt_q;
      in_sr_d     = in_sr_q;
      out_sr_d    = out_sr_q;
      result_d    = result_q;
      ready_d     = ready_q;
      frame_err_d = frame_err_q;
      dir_d       = dir_q;
      key_d       = key_q;
      msg_d       = msg_q;
      ce          = 1'b1;
      start       = 1'b0;

      case (state_q)
         IDLE, ERROR: begin
            if (load_rise) start = 1'b1;
         end
         SHIFT: begin
            if (load_fall) begin
`ifdef AES_SPI_FRAMECHK_EN
               if (bitcnt_q != CNT_W'(FRAME_LEN)) begin
                  state_d     = ERROR;
                  frame_err_d = 1'b1;
               end else begin
                  state_d = RUN;
                  dir_d   = in_sr_q[FRAME_LEN-1];
                  key_d   = in_sr_q[FRAME_LEN-2 -: K];
                  msg_d   = in_sr_q[127:0];
               end
`else
               state_d = RUN;
               dir_d   = in_sr_q[FRAME_LEN-1];
               key_d   = in_sr_q[FRAME_LEN-2 -: K];
               msg_d   = in_sr_q[127:0];
`endif
            end else if (load_s) begin
               if (sck_rise) begin
                  in_sr_d = {in_sr_q[FRAME_LEN-2:0], sdi_s};
                  if (bitcnt_q != CNT_W'(FRAME_LEN)) bitcnt_d = bitcnt_q + 1'b1;
               end
               if (sck_fall) out_sr_d = {out_sr_q[126:0], 1'b0};
            end
         end
         RUN: begin
            ce = 1'b0;
            // A new frame while the core is busy aborts it; the old result stays.
            if (load_rise) begin
               start = 1'b1;
            end else if (done) begin
               result_d = translated;
               ready_d  = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            ce = 1'b0;
            if (load_rise) start = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (start) begin
         state_d     = SHIFT;
         bitcnt_d    = '0;
         ready_d     = 1'b0;
         frame_err_d = 1'b0;
         out_sr_d    = result_q;
      end
   end

   assign sdo       = out_sr_q[127];
   assign ready     = ready_q;
   assign frame_err = frame_err_q;
   assign dir       = dir_q;
   assign key       = key_q;
   assign message   = msg_q;

endmodule
